// File: rtl/cmp_pipe_sched.sv
// cmp_pipe_sched: round-robin scheduler feeding one 3-stage compare datapath.
// Each issued word {D,C,B,A} produces lhs = A|B, rhs = (B&C)^D and
// mismatch = (lhs != rhs), returned three cycles later tagged with its requester ID.
// Build option: define CMP_STATS_EN to compile the saturating issue/mismatch
// counters; without it issued_cnt/mismatch_cnt read 0 and stats_clr is ignored.
module cmp_pipe_sched #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [7:0]         res_lhs,
  output logic [7:0]         res_rhs,
  output logic               res_mismatch,
  output logic               busy,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   issued_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  // Round-robin pointer: index of the most recent winner.
  logic [IDW-1:0] last_q, last_d;

  // Arbitration results.
  logic           hi_found_s, lo_found_s, any_s, transfer_s;
  logic [IDW-1:0] hi_idx_s, lo_idx_s, win_s;
  logic [31:0]    word_s;

  // Pipeline stage registers.
  logic           v1_q, v2_q;
  logic [7:0]     ab_q, bc_q, d_q;
  logic [IDW-1:0] id1_q, id2_q;
  logic [7:0]     lhs_q, rhs_q;
  logic           res_valid_q, res_mm_q;
  logic [IDW-1:0] res_id_q;
  logic [7:0]     res_lhs_q, res_rhs_q;

  // Find the lowest requester above the pointer, else the lowest at/below it (wraps for any NREQ).
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = {IDW{1'b0}};
    lo_idx_s   = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(last_q))) begin
        hi_found_s = 1'b1;
        hi_idx_s   = IDW'(i);
      end else if (req_valid[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = IDW'(i);
      end else begin
        // requester idle this cycle
      end
    end
  end

  // Pick the winner, drive the one-hot grant and select the winning word.
  always_comb begin
    any_s      = hi_found_s | lo_found_s;
    win_s      = hi_found_s ? hi_idx_s : lo_idx_s;
    transfer_s = any_s & en;
    word_s     = 32'h0000_0000;
    req_ready  = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = transfer_s & (win_s == IDW'(i));
      word_s       = word_s | (req_data[32*i +: 32] & {32{win_s == IDW'(i)}});
    end
    last_d = transfer_s ? win_s : last_q;
  end

  // Pointer advances only on an actual transfer; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

  // Three-stage compare pipeline; data registers only load behind a valid so results hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      ab_q        <= 8'h00;
      bc_q        <= 8'h00;
      d_q         <= 8'h00;
      id1_q       <= {IDW{1'b0}};
      id2_q       <= {IDW{1'b0}};
      lhs_q       <= 8'h00;
      rhs_q       <= 8'h00;
      res_valid_q <= 1'b0;
      res_mm_q    <= 1'b0;
      res_id_q    <= {IDW{1'b0}};
      res_lhs_q   <= 8'h00;
      res_rhs_q   <= 8'h00;
    end else begin
      v1_q <= transfer_s;
      if (transfer_s) begin
        ab_q  <= word_s[7:0] | word_s[15:8];
        bc_q  <= word_s[15:8] & word_s[23:16];
        d_q   <= word_s[31:24];
        id1_q <= win_s;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        lhs_q <= ab_q;
        rhs_q <= bc_q ^ d_q;
        id2_q <= id1_q;
      end
      res_valid_q <= v2_q;
      if (v2_q) begin
        res_lhs_q <= lhs_q;
        res_rhs_q <= rhs_q;
        res_mm_q  <= (lhs_q != rhs_q);
        res_id_q  <= id2_q;
      end
    end
  end

  assign res_valid    = res_valid_q;
  assign res_id       = res_id_q;
  assign res_lhs      = res_lhs_q;
  assign res_rhs      = res_rhs_q;
  assign res_mismatch = res_mm_q;
  assign busy         = (|req_valid) | v1_q | v2_q | res_valid_q;

`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      r = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = cnt;
    end
    return r;
  endfunction

  // Counter next state; a clear beats any same-cycle increment.
  always_comb begin
    iss_cnt_d = iss_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (stats_clr) begin
      iss_cnt_d = {CNT_W{1'b0}};
      mis_cnt_d = {CNT_W{1'b0}};
    end else begin
      iss_cnt_d = sat_inc(iss_cnt_q, transfer_s);
      mis_cnt_d = sat_inc(mis_cnt_q, res_valid_q & res_mm_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_cnt_q <= {CNT_W{1'b0}};
      mis_cnt_q <= {CNT_W{1'b0}};
    end else begin
      iss_cnt_q <= iss_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign issued_cnt   = iss_cnt_q;
  assign mismatch_cnt = mis_cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign issued_cnt       = {CNT_W{1'b0}};
  assign mismatch_cnt     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cmp_pipe_sched.sv
// Self-checking bench for cmp_pipe_sched: constant vector table, directed
// multi-cycle sequences, and randomized traffic checked every cycle against a
// queue-based reference model (issue-time + 3 = result time).
module tb_cmp_pipe_sched;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int CNT_W  = 8;
  localparam int CMAX_I = (1 << CNT_W) - 1;
`ifdef CMP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst, en, stats_clr;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*32-1:0] req_data;
  logic               res_valid, res_mismatch, busy;
  logic [IDW-1:0]     res_id;
  logic [7:0]         res_lhs, res_rhs;
  logic [CNT_W-1:0]   issued_cnt, mismatch_cnt;

  cmp_pipe_sched #(.NREQ(NREQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id),
    .res_lhs(res_lhs), .res_rhs(res_rhs), .res_mismatch(res_mismatch),
    .busy(busy), .stats_clr(stats_clr), .issued_cnt(issued_cnt),
    .mismatch_cnt(mismatch_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic [7:0]     lhs;
    logic [7:0]     rhs;
    logic           mm;
  } res_t;

  res_t pq[$];
  res_t last_res;
  int   m_last, m_iss, m_mis;

  initial begin
    logic [NREQ-1:0] e_ready;
    bit              any, e_rv, e_busy;
    int              win, j;
    logic [31:0]     w;
    res_t            r;
    m_last = NREQ - 1;
    m_iss  = 0;
    m_mis  = 0;
    last_res.due = 0; last_res.id = '0; last_res.lhs = 8'h00; last_res.rhs = 8'h00; last_res.mm = 1'b0;
    forever begin
      @(negedge clk);
      any = 1'b0;
      win = 0;
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_last + k) % NREQ;
        if (!any && req_valid[j]) begin
          any = 1'b1;
          win = j;
        end
      end
      e_ready = '0;
      if (any && en) e_ready[win] = 1'b1;
      e_busy = (req_valid != '0) || (pq.size() != 0);
      e_rv = 1'b0;
      if (pq.size() != 0 && pq[0].due == cyc) begin
        e_rv = 1'b1;
        last_res = pq.pop_front();
      end
      if (chk_on) begin
        chk("m_req_ready", req_ready, e_ready);
        chk("m_busy", busy, e_busy);
        chk("m_res_valid", res_valid, e_rv);
        chk("m_res_id", res_id, last_res.id);
        chk("m_res_lhs", res_lhs, last_res.lhs);
        chk("m_res_rhs", res_rhs, last_res.rhs);
        chk("m_res_mismatch", res_mismatch, last_res.mm);
        chk("m_issued_cnt", issued_cnt, m_iss);
        chk("m_mismatch_cnt", mismatch_cnt, m_mis);
      end
      // state after the coming rising edge
      if (rst) begin
        pq.delete();
        m_last = NREQ - 1;
        m_iss = 0;
        m_mis = 0;
        last_res.id = '0; last_res.lhs = 8'h00; last_res.rhs = 8'h00; last_res.mm = 1'b0;
      end else begin
        if (STATS && stats_clr) begin
          m_iss = 0;
          m_mis = 0;
        end else if (STATS) begin
          if (any && en && m_iss < CMAX_I) m_iss++;
          if (e_rv && last_res.mm && m_mis < CMAX_I) m_mis++;
        end
        if (any && en) begin
          w = req_data[32*win +: 32];
          r.due = cyc + 3;
          r.id  = IDW'(win);
          r.lhs = w[7:0] | w[15:8];
          r.rhs = (w[15:8] & w[23:16]) ^ w[31:24];
          r.mm  = (r.lhs != r.rhs);
          pq.push_back(r);
          m_last = win;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int          id;
    logic [31:0] word;
    logic [7:0]  lhs;
    logic [7:0]  rhs;
    logic        mm;
  } vec_t;

  vec_t tab[5];

  initial begin
    logic [NREQ-1:0] exp_r, granted;
    logic [7:0]      a, b, c;
    int              ids[$];
    int              cs[$];

    tab[0] = '{id: 0, word: 32'h0000_0001, lhs: 8'h01, rhs: 8'h00, mm: 1'b1};
    tab[1] = '{id: 2, word: 32'hF0FF_0FF0, lhs: 8'hFF, rhs: 8'hFF, mm: 1'b0};
    tab[2] = '{id: 1, word: 32'h1234_5678, lhs: 8'h7E, rhs: 8'h06, mm: 1'b1};
    tab[3] = '{id: 3, word: 32'hAA00_AA00, lhs: 8'hAA, rhs: 8'hAA, mm: 1'b0};
    tab[4] = '{id: 1, word: 32'hFFFF_FFFF, lhs: 8'hFF, rhs: 8'h00, mm: 1'b1};

    rst = 1'b1; en = 1'b0; stats_clr = 1'b0; req_valid = '0; req_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    en = 1'b1;

    // table vectors: single requester, fixed latency of 3
    for (int t = 0; t < 5; t++) begin
      req_valid = '0;
      req_valid[tab[t].id] = 1'b1;
      req_data[32*tab[t].id +: 32] = tab[t].word;
      exp_r = '0;
      exp_r[tab[t].id] = 1'b1;
      @(negedge clk);
      chk("tab_ready", req_ready, exp_r);
      tick();
      req_valid = '0;
      for (int l = 1; l <= 3; l++) begin
        @(negedge clk);
        if (l < 3) begin
          chk("tab_early_valid", res_valid, 1'b0);
        end else begin
          chk("tab_res_valid", res_valid, 1'b1);
          chk("tab_res_id", res_id, tab[t].id);
          chk("tab_res_lhs", res_lhs, tab[t].lhs);
          chk("tab_res_rhs", res_rhs, tab[t].rhs);
          chk("tab_res_mismatch", res_mismatch, tab[t].mm);
        end
      end
      tick();
    end

    // round robin: all four valid for 8 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 8) ? {NREQ{1'b1}} : {NREQ{1'b0}};
      @(negedge clk);
      if (k < 8) begin
        exp_r = '0;
        exp_r[k % NREQ] = 1'b1;
        chk("rr_grant", req_ready, exp_r);
      end
      if (res_valid) begin
        ids.push_back(int'(res_id));
        cs.push_back(k);
      end
      tick();
      if (k < 8) req_data[32*(k % NREQ) +: 32] = $urandom();
    end
    chk("rr_result_count", ids.size(), 8);
    for (int i = 0; i < ids.size(); i++) begin
      chk("rr_result_id", ids[i], i % NREQ);
      chk("rr_result_cycle", cs[i], i + 3);
    end
    chk("rr_issued_cnt", issued_cnt, STATS ? 8 : 0);

    // en low: no grants, pointer frozen
    en = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("en0_no_grant", req_ready, 4'b0000);
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    chk("en1_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0101;
    @(negedge clk);
    chk("en1_next_rr", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("en1_wrap_rr", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // reset with two words in flight
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_valid_t3", res_valid, 1'b0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_lhs", res_lhs, 8'h00);
    chk("rst_res_rhs", res_rhs, 8'h00);
    chk("rst_res_mismatch", res_mismatch, 1'b0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    chk("rst_no_valid_t4", res_valid, 1'b0);
    tick();
    req_valid = {NREQ{1'b1}};
    @(negedge clk);
    chk("rst_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom());
            req_data[32*i +: 32] = {(a | b) ^ (b & c), c, b, a};
          end else begin
            req_data[32*i +: 32] = $urandom();
          end
        end
      end
      en = ($urandom_range(0, 7) != 0);
      stats_clr = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 150) == 0);
      @(negedge clk);
      granted = req_ready;
      tick();
      req_valid = req_valid & ~granted;
    end
    rst = 1'b0; stats_clr = 1'b0; en = 1'b1; req_valid = '0;
    repeat (5) tick();

    // saturation with continuous mismatching words
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h0000_0001;
    req_valid = {NREQ{1'b1}};
    repeat (300) tick();
    @(negedge clk);
    chk("sat_issued", issued_cnt, STATS ? CMAX_I : 0);
    chk("sat_mismatch", mismatch_cnt, STATS ? CMAX_I : 0);
    tick();
    @(negedge clk);
    chk("sat_issued_hold", issued_cnt, STATS ? CMAX_I : 0);
    chk("sat_mismatch_hold", mismatch_cnt, STATS ? CMAX_I : 0);
    stats_clr = 1'b1;
    chk("clr_coincident_result", res_valid & res_mismatch, 1'b1);
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("clr_mismatch", mismatch_cnt, 0);
    chk("clr_issued", issued_cnt, 0);
    tick();
    @(negedge clk);
    chk("clr_mismatch_resume", mismatch_cnt, STATS ? 1 : 0);
    chk("clr_issued_resume", issued_cnt, STATS ? 1 : 0);
    tick();
    req_valid = '0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_pipe_sched.md
Name: cmp_pipe_sched

Overview:
- Round-robin scheduler that shares one 3-stage compare datapath among NREQ requesters.
- The datapath computes mismatch = (A | B) != ((B & C) ^ D) on 8-bit fields.
- Each requester presents a packed 32-bit word; one word is issued per cycle.
- Results return tagged with the requester ID.
- Sits between the counter/stimulus sources and downstream checkers.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; 2**IDW >= NREQ
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  issue enable; 0 = no new grants, pipeline keeps draining
req_valid  input  NREQ  per-requester word valid
req_data  input  NREQ*32  requester i word at [32*i+31:32*i]; A=[7:0], B=[15:8], C=[23:16], D=[31:24]
req_ready  output  NREQ  one-hot-or-zero grant; transfer when valid & ready
res_valid  output  1  result valid, one-cycle pulse per issued word
res_id  output  IDW  requester ID of result
res_lhs  output  8  A | B of issued word
res_rhs  output  8  (B & C) ^ D of issued word
res_mismatch  output  1  res_lhs != res_rhs
busy  output  1  any req_valid or any pipeline stage valid
stats_clr  input  1  synchronous clear of statistics counters
issued_cnt  output  CNT_W  words issued (saturating)
mismatch_cnt  output  CNT_W  results with mismatch=1 (saturating)

Behaviour:
- Reset: all outputs 0; RR pointer last=NREQ-1, so requester 0 has first priority; all stage valids cleared.
- Reset mid-operation: in-flight words dropped; no res_valid until a new issue completes.
- Arbitration:
  - Combinational search from last+1 upward, wrapping modulo NREQ.
  - Winner = first i with req_valid[i]; req_ready[winner]=en, all other ready bits 0.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
  - Valid and data are held stable until transfer.
  - On transfer, last <= winner; pointer is unchanged on idle or when en=0.
  - Winner index must wrap correctly when NREQ is not a power of two.
- Pipeline, transfer in cycle T:
  - S1 (edge ending T): registers A|B, B&C, D, id, v1.
  - S2 (edge T+1): registers lhs=A|B, rhs=(B&C)^D, id, v2.
  - S3 (edge T+2): registers res_lhs, res_rhs, res_mismatch, res_id, res_valid=v2.
  - res_valid is high in cycle T+3; latency is fixed at 3; no stall and no backpressure.
- Throughput: one issue per cycle; back-to-back results from consecutive cycles are produced with no bubbles.
- Outputs: res_* data fields hold their last values when res_valid=0; checkers sample only on res_valid.
- busy is combinational: |req_valid | v1 | v2 | res_valid.
- Stats:
  - issued_cnt increments on transfer; mismatch_cnt increments when res_valid & res_mismatch.
  - Both saturate at 2**CNT_W-1.
  - stats_clr wins over a simultaneous increment (result 0); a clear does not affect the pipeline.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined: issued_cnt and mismatch_cnt behave as described above.
- Undefined: counter logic is not compiled; issued_cnt and mismatch_cnt tied to 0; stats_clr ignored. Ports remain present in both builds.

Test Plan:
- Req0 only, word 0x00000001 (A=0x01), en=1 at T → req_ready[0]=1 at T; res_valid at T+3, res_id=0, res_lhs=0x01, res_rhs=0x00, res_mismatch=1.
- Req2 only, word 0xF0FF0FF0 (A=F0, B=0F, C=FF, D=F0) → res_lhs=0xFF, res_rhs=0xFF, res_mismatch=0, res_id=2, latency 3.
- All four req_valid held high for 8 cycles with distinct words → grant order 0,1,2,3,0,1,2,3; res_valid high for 8 consecutive cycles with IDs in the same order; issued_cnt=8.
- en=0 with req1 valid for 3 cycles, then en=1 → no grants while low; req_ready[1] on the first en=1 cycle; RR pointer unchanged during en=0.
- Issue at cycles T and T+1, assert rst in T+2 → no res_valid at T+3/T+4; all outputs 0; after release req0 granted first.
- CMP_STATS_EN defined, CNT_W=16, counters preloaded near 0xFFFF via repeated mismatching issues → counters hold at 0xFFFF; stats_clr coincident with a mismatch result → mismatch_cnt=0 next cycle.
